// File: rtl/exc_sched_pkg.sv
// Shared exception codes, FSM state encoding and result struct for exc_sched.
package exc_sched_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;
  localparam logic [4:0] EXC_NONE = 5'h10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] badvaddr;
  } exc_t;

endpackage

// File: rtl/exc_sched_if.sv
// MEM-stage / CP0 bundle seen by the exception scheduler.
interface exc_sched_if #(
  parameter int unsigned INT_W = 6
);
  logic [INT_W-1:0] int_i;
  logic             timer_int_i;
  logic [31:0]      status_i;
  logic [31:0]      cause_i;
  logic             inst_valid_i;
  logic [31:0]      pc_i;
  logic             in_delay_i;
  logic [31:0]      mem_addr_i;
  logic             if_adel_i;
  logic             ri_i;
  logic             ov_i;
  logic             sys_i;
  logic             bp_i;
  logic             eret_i;
  logic             mem_adel_i;
  logic             mem_ades_i;
  logic [INT_W-1:0] cp0_int_o;
  logic [4:0]       exccode_o;
  logic [31:0]      exc_pc_o;
  logic             exc_in_delay_o;
  logic [31:0]      exc_badvaddr_o;
  logic             int_pending_o;
  logic             squash_o;

  // Pipeline/CP0 side
  modport master (
    output int_i, timer_int_i, status_i, cause_i, inst_valid_i, pc_i, in_delay_i,
           mem_addr_i, if_adel_i, ri_i, ov_i, sys_i, bp_i, eret_i, mem_adel_i, mem_ades_i,
    input  cp0_int_o, exccode_o, exc_pc_o, exc_in_delay_o, exc_badvaddr_o,
           int_pending_o, squash_o
  );

  // Scheduler side
  modport slave (
    input  int_i, timer_int_i, status_i, cause_i, inst_valid_i, pc_i, in_delay_i,
           mem_addr_i, if_adel_i, ri_i, ov_i, sys_i, bp_i, eret_i, mem_adel_i, mem_ades_i,
    output cp0_int_o, exccode_o, exc_pc_o, exc_in_delay_o, exc_badvaddr_o,
           int_pending_o, squash_o
  );
endinterface

// File: rtl/exc_sched_int_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous interrupt line.
module int_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw line through the synchroniser chain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/exc_sched.sv
// MEM-stage exception/interrupt scheduler: interrupt sync, priority encode,
// and a squash window after each taken exception or ERET.
module exc_sched
  import exc_sched_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SQUASH_CYC  = 2,
  parameter int unsigned INT_W       = 6
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  exc_sched_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(SQUASH_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SQUASH_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [INT_W-1:0] w_sync;
  logic             w_pend;
  logic             w_take;
  exc_t             w_exc;

  for (genvar g = 0; g < INT_W; g++) begin : g_sync
    int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (cpu_clk_50M),
      .i_rst_n (cpu_rst_n),
      .i_d     (bus.int_i[g]),
      .o_q     (w_sync[g])
    );
  end

  // Timer joins the top line undelayed; forced low while reset is held
  assign bus.cp0_int_o = cpu_rst_n ? {w_sync[INT_W-1] | bus.timer_int_i, w_sync[INT_W-2:0]}
                                   : '0;

  assign w_pend = (|(bus.cause_i[15:8] & bus.status_i[15:8])) & bus.status_i[0] & ~bus.status_i[1];

  // Reset gates the take condition so no code escapes while reset is asserted
  assign w_take = cpu_rst_n & bus.inst_valid_i & (r_state != ST_SQUASH);

  // Priority encoder: interrupt first, then instruction flags in fixed order
  always_comb begin
    w_exc.code     = EXC_NONE;
    w_exc.badvaddr = '0;
    if (w_take) begin
      if (r_state == ST_ARMED || w_pend) begin
        w_exc.code = EXC_INT;
      end else if (bus.if_adel_i) begin
        w_exc.code     = EXC_ADEL;
        w_exc.badvaddr = bus.pc_i;
      end else if (bus.ri_i) begin
        w_exc.code = EXC_RI;
      end else if (bus.ov_i) begin
        w_exc.code = EXC_OV;
      end else if (bus.sys_i) begin
        w_exc.code = EXC_SYS;
      end else if (bus.bp_i) begin
        w_exc.code = EXC_BP;
      end else if (bus.eret_i) begin
        w_exc.code = EXC_ERET;
      end else if (bus.mem_adel_i) begin
        w_exc.code     = EXC_ADEL;
        w_exc.badvaddr = bus.mem_addr_i;
      end else if (bus.mem_ades_i) begin
        w_exc.code     = EXC_ADES;
        w_exc.badvaddr = bus.mem_addr_i;
      end
    end
  end

  // Next-state and squash counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_exc.code != EXC_NONE) begin
          w_state_nxt = ST_SQUASH;
          w_cnt_nxt   = CNT_LOAD;
        end else if (w_pend) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_take) begin
          w_state_nxt = ST_SQUASH;
          w_cnt_nxt   = CNT_LOAD;
        end else if (!w_pend) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SQUASH: begin
        if (r_cnt == '0) w_state_nxt = w_pend ? ST_ARMED : ST_RUN;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State and counter registers
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.exccode_o      = w_exc.code;
  assign bus.exc_badvaddr_o = w_exc.badvaddr;
  assign bus.exc_pc_o       = bus.pc_i;
  assign bus.exc_in_delay_o = bus.in_delay_i;
  assign bus.int_pending_o  = (r_state == ST_ARMED);
  assign bus.squash_o       = (r_state == ST_SQUASH);

endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched with hand-computed expected values.
module tb_exc_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exc_sched_if #(.INT_W(6)) bus ();

  exc_sched #(.SYNC_STAGES(2), .SQUASH_CYC(2), .INT_W(6)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .bus         (bus)
  );

  // CP0 cause IP[7:2] mirrors the hardware interrupt vector
  assign bus.cause_i = {16'h0000, bus.cp0_int_o, 10'h000};

  // {if_adel, ri, ov, sys, bp, eret, mem_adel, mem_ades}
  logic [7:0]  pv_flags [8];
  logic [4:0]  pv_code  [8];
  logic [31:0] pv_bad   [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [7:0] v);
    bus.if_adel_i  = v[7];
    bus.ri_i       = v[6];
    bus.ov_i       = v[5];
    bus.sys_i      = v[4];
    bus.bp_i       = v[3];
    bus.eret_i     = v[2];
    bus.mem_adel_i = v[1];
    bus.mem_ades_i = v[0];
  endtask

  initial begin
    pv_flags = '{8'b0000_0001, 8'b1000_0001, 8'b0100_0010, 8'b0011_0000,
                 8'b0001_1000, 8'b0000_1100, 8'b0000_0110, 8'b0000_0011};
    pv_code  = '{5'h05, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h0e, 5'h04};
    pv_bad   = '{32'h8000_0003, 32'hbfc0_0102, 32'h0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h8000_0003};

    bus.int_i        = '0;
    bus.timer_int_i  = 1'b0;
    bus.status_i     = '0;
    bus.inst_valid_i = 1'b0;
    bus.pc_i         = 32'hbfc0_0000;
    bus.in_delay_i   = 1'b0;
    bus.mem_addr_i   = '0;
    set_flags(8'h00);

    // Reset state
    #2;
    check("rst_exccode", 32'(bus.exccode_o), 32'h10);
    check("rst_squash", 32'(bus.squash_o), 32'h0);
    check("rst_pending", 32'(bus.int_pending_o), 32'h0);
    check("rst_cp0_int", 32'(bus.cp0_int_o), 32'h0);
    bus.timer_int_i  = 1'b1;
    bus.inst_valid_i = 1'b1;
    bus.ov_i         = 1'b1;
    #1;
    check("rst_cp0_int_timer", 32'(bus.cp0_int_o), 32'h0);
    check("rst_exccode_ov", 32'(bus.exccode_o), 32'h10);
    bus.timer_int_i  = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.ov_i         = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Overflow then squash window
    bus.inst_valid_i = 1'b1;
    bus.ov_i         = 1'b1;
    #2;
    check("ov_code", 32'(bus.exccode_o), 32'h0c);
    check("ov_squash0", 32'(bus.squash_o), 32'h0);
    check("ov_badvaddr", bus.exc_badvaddr_o, 32'h0);
    tick();
    check("sq1_squash", 32'(bus.squash_o), 32'h1);
    check("sq1_code", 32'(bus.exccode_o), 32'h10);
    tick();
    check("sq2_squash", 32'(bus.squash_o), 32'h1);
    check("sq2_code", 32'(bus.exccode_o), 32'h10);
    tick();
    check("sq_end_squash", 32'(bus.squash_o), 32'h0);
    check("sq_end_code", 32'(bus.exccode_o), 32'h0c);
    bus.inst_valid_i = 1'b0;
    bus.ov_i         = 1'b0;
    #2;
    check("novalid_code", 32'(bus.exccode_o), 32'h10);
    tick();

    // Flag priority table (combinational, state RUN)
    bus.inst_valid_i = 1'b1;
    bus.mem_addr_i   = 32'h8000_0003;
    bus.pc_i         = 32'hbfc0_0102;
    bus.in_delay_i   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_flags(pv_flags[i]);
      #1;
      check($sformatf("prio%0d_code", i), 32'(bus.exccode_o), 32'(pv_code[i]));
      check($sformatf("prio%0d_bad", i), bus.exc_badvaddr_o, pv_bad[i]);
    end
    check("exc_pc", bus.exc_pc_o, 32'hbfc0_0102);
    check("exc_in_delay", 32'(bus.exc_in_delay_o), 32'h1);
    set_flags(8'h00);
    bus.inst_valid_i = 1'b0;
    bus.in_delay_i   = 1'b0;
    #1;
    tick();

    // External interrupt through the synchroniser
    bus.status_i = 32'h1000_0401;
    bus.int_i    = 6'b000001;
    tick();
    check("sync1_cp0_int", 32'(bus.cp0_int_o), 32'h0);
    tick();
    check("sync2_cp0_int", 32'(bus.cp0_int_o), 32'h1);
    check("sync2_pending", 32'(bus.int_pending_o), 32'h0);
    tick();
    check("armed_pending", 32'(bus.int_pending_o), 32'h1);
    tick();
    tick();
    check("armed5_pending", 32'(bus.int_pending_o), 32'h1);
    check("armed5_code", 32'(bus.exccode_o), 32'h10);
    bus.inst_valid_i = 1'b1;
    bus.ri_i         = 1'b1;
    #2;
    check("int_take_code", 32'(bus.exccode_o), 32'h00);
    check("int_take_bad", bus.exc_badvaddr_o, 32'h0);
    tick();
    check("int_sq1_squash", 32'(bus.squash_o), 32'h1);
    check("int_sq1_code", 32'(bus.exccode_o), 32'h10);
    check("int_sq1_pending", 32'(bus.int_pending_o), 32'h0);
    tick();
    check("int_sq2_code", 32'(bus.exccode_o), 32'h10);
    tick();
    check("int_after_sq_code", 32'(bus.exccode_o), 32'h00);
    check("int_after_sq_pending", 32'(bus.int_pending_o), 32'h1);
    bus.status_i     = '0;
    bus.inst_valid_i = 1'b0;
    bus.ri_i         = 1'b0;
    #2;
    tick();
    check("int_cleared_pending", 32'(bus.int_pending_o), 32'h0);
    check("int_cleared_squash", 32'(bus.squash_o), 32'h0);

    // EXL blocks interrupts; clearing IE path while armed returns to RUN
    bus.status_i     = 32'h0000_0403;
    bus.inst_valid_i = 1'b1;
    #2;
    check("exl_code", 32'(bus.exccode_o), 32'h10);
    bus.inst_valid_i = 1'b0;
    tick();
    check("exl_pending", 32'(bus.int_pending_o), 32'h0);
    bus.status_i = 32'h0000_0401;
    tick();
    check("exl_clr_pending", 32'(bus.int_pending_o), 32'h1);
    bus.status_i = 32'h0000_0403;
    tick();
    check("disarm_pending", 32'(bus.int_pending_o), 32'h0);
    check("disarm_squash", 32'(bus.squash_o), 32'h0);
    bus.int_i    = '0;
    bus.status_i = '0;
    tick();
    tick();
    tick();
    check("int_line_low", 32'(bus.cp0_int_o), 32'h0);

    // Timer interrupt beats RI
    bus.status_i     = 32'h0000_8001;
    bus.timer_int_i  = 1'b1;
    bus.ri_i         = 1'b1;
    bus.inst_valid_i = 1'b1;
    #2;
    check("timer_cp0_int", 32'(bus.cp0_int_o), 32'h20);
    check("timer_code", 32'(bus.exccode_o), 32'h00);
    tick();
    check("timer_squash", 32'(bus.squash_o), 32'h1);
    bus.timer_int_i = 1'b0;
    bus.ri_i        = 1'b0;
    bus.ov_i        = 1'b1;
    #2;
    check("timer_sq_code", 32'(bus.exccode_o), 32'h10);

    // Asynchronous reset mid-squash
    rst_n = 1'b0;
    #1;
    check("arst_squash", 32'(bus.squash_o), 32'h0);
    check("arst_code", 32'(bus.exccode_o), 32'h10);
    check("arst_pending", 32'(bus.int_pending_o), 32'h0);
    bus.ov_i         = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.status_i     = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_squash", 32'(bus.squash_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
